// File: rtl/grf_wb_if.sv
// W-stage write-back bus and D-stage read ports of the general register file.
// The pipeline (master) drives the W-stage fields and read addresses; the GRF (slave) returns read data and WD_W.
interface grf_wb_if;
   logic [31:0] ALUOut_W;
   logic [31:0] DMOut_W;
   logic [31:0] PC_W;
   logic [31:0] instr_W;
   logic [4:0]  WriteReg_W;
   logic        RegWrite_W;
   logic [1:0]  WDSrc_W;
   logic [1:0]  Tnew_W;
   logic [4:0]  A1_D;
   logic [4:0]  A2_D;
   logic [31:0] RD1_D;
   logic [31:0] RD2_D;
   logic [31:0] WD_W;

   // Plain per-cycle bus with no valid/ready handshake: the GRF samples
   // every rising edge, and a bubble is signalled as instr_W=0, RegWrite_W=0.
   modport master (
      output ALUOut_W, DMOut_W, PC_W, instr_W, WriteReg_W, RegWrite_W,
             WDSrc_W, Tnew_W, A1_D, A2_D,
      input  RD1_D, RD2_D, WD_W
   );

   modport slave (
      input  ALUOut_W, DMOut_W, PC_W, instr_W, WriteReg_W, RegWrite_W,
             WDSrc_W, Tnew_W, A1_D, A2_D,
      output RD1_D, RD2_D, WD_W
   );
endinterface

// File: rtl/grf_wb.sv
// Write-back stage: commits W-stage results to the 32x32 GRF, serves two bypassed
// read ports, and keeps a retire counter, last-commit trace and sticky protocol-error flag.
module grf_wb #(
   parameter logic [31:0] PC_LINK_OFFSET = 32'd8,
   parameter int          RETIRE_W       = 32
) (
   input  logic                clk,
   input  logic                reset,
   grf_wb_if.slave             bus,
   output logic [RETIRE_W-1:0] retire_cnt,
   output logic [31:0]         last_wr_pc,
   output logic [4:0]          last_wr_reg,
   output logic [31:0]         last_wr_data,
   output logic                proto_err
);

   logic [31:0] grf [32];
   logic [31:0] wd;
   logic        wb_ok;
   logic        we;
   logic        err_now;
   logic        retire;

   always_comb begin
      wd = 32'd0;
      unique case (bus.WDSrc_W)
         2'b00:   wd = bus.ALUOut_W;
         2'b01:   wd = bus.DMOut_W;
         2'b10:   wd = bus.PC_W + PC_LINK_OFFSET;
         default: wd = 32'd0;
      endcase
   end

   assign bus.WD_W = wd;

   // wb_ok is the write intent ignoring the destination; both commit and bypass use it.
   assign wb_ok   = bus.RegWrite_W && (bus.WDSrc_W != 2'b11) && (bus.Tnew_W == 2'd0);
   assign we      = wb_ok && (bus.WriteReg_W != 5'd0);
   assign err_now = (bus.RegWrite_W && (bus.WDSrc_W == 2'b11)) ||
                    ((bus.instr_W != 32'd0) && (bus.Tnew_W != 2'd0));
   assign retire  = (bus.instr_W != 32'd0);

   // Bypass is gated by reset so reads show 0 while the file is being held clear.
   always_comb begin
      bus.RD1_D = grf[bus.A1_D];
      if (bus.A1_D == 5'd0 || !reset)
         bus.RD1_D = 32'd0;
      else if (wb_ok && bus.A1_D == bus.WriteReg_W)
         bus.RD1_D = wd;
   end

   always_comb begin
      bus.RD2_D = grf[bus.A2_D];
      if (bus.A2_D == 5'd0 || !reset)
         bus.RD2_D = 32'd0;
      else if (wb_ok && bus.A2_D == bus.WriteReg_W)
         bus.RD2_D = wd;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) grf[i] <= 32'd0;
      end else if (we) begin
         grf[bus.WriteReg_W] <= wd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_wr_pc   <= 32'd0;
         last_wr_reg  <= 5'd0;
         last_wr_data <= 32'd0;
      end else if (we) begin
         last_wr_pc   <= bus.PC_W;
         last_wr_reg  <= bus.WriteReg_W;
         last_wr_data <= wd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retire_cnt <= '0;
         proto_err  <= 1'b0;
      end else begin
         if (retire) retire_cnt <= retire_cnt + {{(RETIRE_W-1){1'b0}}, 1'b1};
         if (err_now) proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_grf_wb.sv
// Self-checking bench for grf_wb: directed scenarios plus randomized traffic
// against an array-based reference model of the register file.
module tb_grf_wb;
   localparam int RW = 4;

   logic          clk;
   logic          reset;
   logic [RW-1:0] retire_cnt;
   logic [31:0]   last_wr_pc;
   logic [4:0]    last_wr_reg;
   logic [31:0]   last_wr_data;
   logic          proto_err;

   grf_wb_if bus ();

   grf_wb #(.PC_LINK_OFFSET(32'd8), .RETIRE_W(RW)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus.slave),
      .retire_cnt   (retire_cnt),
      .last_wr_pc   (last_wr_pc),
      .last_wr_reg  (last_wr_reg),
      .last_wr_data (last_wr_data),
      .proto_err    (proto_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [31:0] m_grf [32];
   int unsigned m_ret;
   logic [31:0] m_pc;
   logic [4:0]  m_reg;
   logic [31:0] m_data;
   logic        m_err;

   int n_vec;
   int n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_clear();
      for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
      m_ret  = 0;
      m_pc   = 32'd0;
      m_reg  = 5'd0;
      m_data = 32'd0;
      m_err  = 1'b0;
   endtask

   function automatic logic [31:0] m_wd();
      case (bus.WDSrc_W)
         2'd0:    return bus.ALUOut_W;
         2'd1:    return bus.DMOut_W;
         2'd2:    return bus.PC_W + 32'd8;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_writes();
      return bus.RegWrite_W && bus.WDSrc_W != 2'd3 && bus.Tnew_W == 2'd0;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (!reset || a == 5'd0) return 32'd0;
      if (m_writes() && a == bus.WriteReg_W) return m_wd();
      return m_grf[a];
   endfunction

   task automatic m_commit();
      if (m_writes() && bus.WriteReg_W != 5'd0) begin
         m_grf[bus.WriteReg_W] = m_wd();
         m_pc   = bus.PC_W;
         m_reg  = bus.WriteReg_W;
         m_data = m_wd();
      end
      if (bus.instr_W != 32'd0) m_ret = (m_ret + 1) % (1 << RW);
      if ((bus.RegWrite_W && bus.WDSrc_W == 2'd3) || (bus.instr_W != 32'd0 && bus.Tnew_W != 2'd0))
         m_err = 1'b1;
   endtask

   // driver
   task automatic drive(input logic rw, input logic [4:0] wr, input logic [1:0] src,
                        input logic [1:0] tnew, input logic [31:0] instr,
                        input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc,
                        input logic [4:0] a1, input logic [4:0] a2);
      bus.RegWrite_W = rw;
      bus.WriteReg_W = wr;
      bus.WDSrc_W    = src;
      bus.Tnew_W     = tnew;
      bus.instr_W    = instr;
      bus.ALUOut_W   = alu;
      bus.DMOut_W    = dm;
      bus.PC_W       = pc;
      bus.A1_D       = a1;
      bus.A2_D       = a2;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".retire"}, 32'(retire_cnt), m_ret);
      check({tag, ".last_pc"}, last_wr_pc, m_pc);
      check({tag, ".last_reg"}, 32'(last_wr_reg), 32'(m_reg));
      check({tag, ".last_data"}, last_wr_data, m_data);
      check({tag, ".proto_err"}, 32'(proto_err), 32'(m_err));
   endtask

   // Called at a negedge after drive(): checks comb outputs, clocks once, checks state.
   task automatic step(input string tag);
      #1;
      check({tag, ".rd1"}, bus.RD1_D, m_read(bus.A1_D));
      check({tag, ".rd2"}, bus.RD2_D, m_read(bus.A2_D));
      check({tag, ".wd"}, bus.WD_W, m_wd());
      @(posedge clk);
      if (reset) m_commit();
      #1;
      check_regs(tag);
      @(negedge clk);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear before any clock edge.
   task automatic do_reset(input string tag);
      #2 reset = 1'b0;
      #1;
      m_clear();
      check_regs(tag);
      check({tag, ".rd1"}, bus.RD1_D, 32'd0);
      check({tag, ".rd2"}, bus.RD2_D, 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   logic [1:0] r_src;
   logic [1:0] r_tnew;

   initial begin
      n_vec = 0;
      n_err = 0;
      m_clear();
      reset = 1'b0;
      drive(1'b1, 5'd5, 2'd0, 2'd0, 32'h1, 32'h1234, 32'd0, 32'd0, 5'd5, 5'd5);
      @(negedge clk);

      // held in reset with a live write request
      step("rst_hold");
      check("rst_hold.rd1_zero", bus.RD1_D, 32'd0);
      reset = 1'b1;
      step("rst_release");
      drive(1'b0, 5'd0, 2'd0, 2'd0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
      #1 check("grf5", bus.RD1_D, 32'h1234);
      step("grf5_rd");

      // write-back select
      drive(1'b1, 5'd1, 2'd0, 2'd0, 32'h11, 32'hA, 32'hB, 32'h3000, 5'd0, 5'd0);
      step("sel_alu");
      drive(1'b1, 5'd2, 2'd1, 2'd0, 32'h12, 32'hA, 32'hB, 32'h3000, 5'd1, 5'd0);
      step("sel_dm");
      drive(1'b1, 5'd31, 2'd2, 2'd0, 32'h13, 32'hA, 32'hB, 32'h3000, 5'd2, 5'd1);
      step("sel_link");
      check("sel_link.last_data", last_wr_data, 32'h3008);
      drive(1'b0, 5'd0, 2'd0, 2'd0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2);
      #1 check("sel.rd_a", bus.RD1_D, 32'hA);
      check("sel.rd_b", bus.RD2_D, 32'hB);
      step("sel_rd12");
      drive(1'b0, 5'd0, 2'd0, 2'd0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd31, 5'd31);
      #1 check("sel.rd_link", bus.RD1_D, 32'h3008);
      step("sel_rd31");

      // bypass
      drive(1'b1, 5'd7, 2'd0, 2'd0, 32'h20, 32'hDEAD, 32'd0, 32'h4000, 5'd7, 5'd7);
      #1 check("byp.rd1", bus.RD1_D, 32'hDEAD);
      check("byp.rd2", bus.RD2_D, 32'hDEAD);
      step("byp");
      drive(1'b0, 5'd0, 2'd0, 2'd0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd0);
      step("byp_after");

      // $0 guard
      drive(1'b1, 5'd0, 2'd0, 2'd0, 32'h21, 32'hFFFF, 32'd0, 32'h5000, 5'd0, 5'd0);
      step("zero_wr");
      check("zero_wr.last_reg", 32'(last_wr_reg), 32'd7);

      // protocol error: reserved select, then 10 clean commits
      drive(1'b1, 5'd3, 2'd3, 2'd0, 32'h22, 32'h55, 32'd0, 32'h6000, 5'd3, 5'd0);
      step("err_src");
      check("err_src.flag", 32'(proto_err), 32'd1);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 5'(8 + i), 2'd0, 2'd0, 32'h30 + i, 32'h100 + i, 32'd0, 32'h7000, 5'd3, 5'(8 + i));
         step("err_hold");
      end
      check("err_hold.flag", 32'(proto_err), 32'd1);

      // protocol error: nonzero Tnew
      do_reset("rst_mid1");
      drive(1'b1, 5'd4, 2'd0, 2'd1, 32'h40, 32'h77, 32'd0, 32'h8000, 5'd4, 5'd4);
      step("err_tnew");
      check("err_tnew.flag", 32'(proto_err), 32'd1);
      drive(1'b0, 5'd0, 2'd0, 2'd0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd4, 5'd0);
      step("err_tnew_rd");

      // retire wrap and bubbles
      do_reset("rst_mid2");
      for (int i = 0; i < (1 << RW) - 2; i++) begin
         drive(1'b0, 5'd0, 2'd0, 2'd0, 32'h50 + i, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
         step("ret_fill");
      end
      check("ret_near_max", 32'(retire_cnt), 32'((1 << RW) - 2));
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 2'd0, 2'd0, 32'h60 + i, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
         step("ret_wrap");
      end
      check("ret_wrapped", 32'(retire_cnt), 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 2'd0, 2'd0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
         step("ret_bubble");
      end
      check("ret_bubble_hold", 32'(retire_cnt), 32'd1);

      // async reset after writes land
      drive(1'b1, 5'd9, 2'd0, 2'd0, 32'h70, 32'hCAFE, 32'd0, 32'h9000, 5'd9, 5'd9);
      step("pre_rst");
      drive(1'b1, 5'd10, 2'd1, 2'd0, 32'h71, 32'd0, 32'hBEEF, 32'h9004, 5'd9, 5'd1);
      do_reset("rst_async");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         r_src  = ($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, 2));
         r_tnew = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), r_src, r_tnew,
               ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
               $urandom, $urandom, $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         if (i % 150 == 149) do_reset("rnd_rst");
         else step("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
